output_mem: RTL and testbench
=============================

OUTPUT_MEM -- requirements
Module: output_mem

Interface
- REQ-001: Parameter BASE_MEM, default 20'h43c01, SHALL be the paddr[31:12] decode for the capture-memory read window.
- REQ-002: Parameter BASE_REG, default 20'h43c02, SHALL be the paddr[31:12] decode for the control/status register window.
- REQ-003: S_APB_aclk  in  1  sole clock; every flop is rising-edge.
- REQ-004: S_APB_aresetn  in  1  reset, asynchronous, active-low.
- REQ-005: S_APB_paddr in 32, S_APB_psel in 1, S_APB_penable in 1, S_APB_pwrite in 1, S_APB_pwdata in 32 SHALL form the APB request.
- REQ-006: S_APB_prdata out 32, S_APB_pready out 1, S_APB_pslverr out 1 SHALL form the APB response.
- REQ-007: Capture_start  in  1  asynchronous arm request; rising edge arms a capture.
- REQ-008: S_AXIS_tdata in 32, S_AXIS_tvalid in 1, S_AXIS_tlast in 1 SHALL be the stream input; S_AXIS_tready out 1 SHALL be the backpressure.
- REQ-009: Busy out 1 (capture in progress), Done out 1 (capture finished), Overflow out 1 (1024 words taken without tlast), Rx_Length out 12 (words captured).

Function
- REQ-010: Capture_start SHALL pass through a 2-flop synchronizer; an arm event is sync pair == 2'b01 (one pulse per rising edge).
- REQ-011: An APB write to BASE_REG offset 0x0 with pwdata[0]=1 SHALL also be an arm event.
- REQ-012: FSM states IDLE, RECV, DONE; reset state IDLE.
- REQ-013: IDLE or DONE + arm event -> RECV next cycle; word counter, Rx_Length, Done, Overflow cleared to 0 on that transition.
- REQ-014: Arm events while in RECV SHALL be ignored.
- REQ-015: S_AXIS_tready SHALL be 1 only in RECV, registered-state driven (no combinational path from tvalid).
- REQ-016: In RECV, each cycle with tvalid & tready SHALL write tdata to Mem[counter[9:0]] and increment counter (0..1024, 12-bit).
- REQ-017: Beat accepted with tlast=1 -> DONE next cycle, Rx_Length = counter+1, Done=1, Overflow=0.
- REQ-018: 1024th beat accepted with tlast=0 -> DONE next cycle, Rx_Length=1024, Done=1, Overflow=1; no further writes; memory never wraps.
- REQ-019: 1024th beat with tlast=1 SHALL be a normal end: Rx_Length=1024, Overflow=0.
- REQ-020: Busy SHALL equal (state==RECV); Done/Overflow hold until next arm event.
- REQ-021: Memory SHALL be 1024x32, one write port (stream), one synchronous read port (APB).
- REQ-022: APB access = psel & penable & ~pready; S_APB_pready SHALL pulse 1 for exactly one cycle, the cycle after the access cycle (1 wait state).
- REQ-023: APB read with paddr[31:12]==BASE_MEM SHALL return Mem[paddr[11:2]] on prdata in the pready cycle; same-cycle stream write to that address returns the old data.
- REQ-024: APB read BASE_REG offset 0x0 SHALL return {28'h0, Overflow, Done, Busy, 1'b0}; offset 0x4 SHALL return {20'h0, Rx_Length}.
- REQ-025: Reads of any other address SHALL return 32'h0; writes other than REQ-011 SHALL be ignored; writes to BASE_MEM SHALL not modify memory.
- REQ-026: S_APB_prdata SHALL be 32'h0 outside the pready cycle; S_APB_pslverr SHALL be tied 0.

Reset
- REQ-027: On aresetn low, immediately: state IDLE, tready 0, Busy/Done/Overflow 0, Rx_Length 0, counter 0, pready 0, prdata 0, sync flops 0.
- REQ-028: Reset mid-capture SHALL abort with no Done; memory contents are not cleared and are unspecified.
- REQ-029: Capture_start held high across reset release SHALL not arm (sync flops restart at 0, next edge needed... only a 0->1 after release arms).

Verification
- REQ-030: Arm via Capture_start, stream 4 beats 0x11,0x22,0x33,0x44 with tlast on 4th -> Done=1, Rx_Length=4, APB reads 0x43c01000..0x43c0100C return 0x11..0x44, pready one cycle each.
- REQ-031: tvalid toggled every other cycle during 8-beat packet -> only handshake cycles written; Rx_Length=8, data contiguous.
- REQ-032: 1030 beats, no tlast -> tready drops after beat 1024, Overflow=1, Rx_Length=1024, Mem[0] not overwritten.
- REQ-033: APB write 0x43c02000=0x1 while in RECV -> ignored; after Done, same write -> Busy=1, Done=0, Rx_Length=0.
- REQ-034: Assert aresetn low after 3 accepted beats -> tready=0, status read 0x43c02000 returns 0x0 after release; read of 0x43c03000 returns 0x0.

Source files
------------

// File: rtl/output_mem.sv
// output_mem: AXI-Stream packet capture into a 1024x32 buffer, read back and controlled over APB.
module output_mem #(
    parameter logic [19:0] BASE_MEM = 20'h43c01,
    parameter logic [19:0] BASE_REG = 20'h43c02
) (
    input  logic        S_APB_aclk,
    input  logic        S_APB_aresetn,
    input  logic [31:0] S_APB_paddr,
    input  logic        S_APB_psel,
    input  logic        S_APB_penable,
    input  logic        S_APB_pwrite,
    input  logic [31:0] S_APB_pwdata,
    output logic [31:0] S_APB_prdata,
    output logic        S_APB_pready,
    output logic        S_APB_pslverr,
    input  logic        Capture_start,
    input  logic [31:0] S_AXIS_tdata,
    input  logic        S_AXIS_tvalid,
    input  logic        S_AXIS_tlast,
    output logic        S_AXIS_tready,
    output logic        Busy,
    output logic        Done,
    output logic        Overflow,
    output logic [11:0] Rx_Length
);
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_sync;
    logic        r_live, r_ok;
    logic [11:0] r_cnt, r_len;
    logic        r_done, r_ovf;
    logic [31:0] r_mem [1024];
    logic [31:0] r_mem_rd, r_reg_rd;
    logic        r_sel_mem, r_pready;
    logic        w_recv, w_beat, w_end, w_apb_acc, w_cs_arm, w_reg_arm, w_arm;
    logic [31:0] w_reg_val;
    logic        w_unused;

    assign w_recv    = r_state == S_RECV;
    assign w_beat    = w_recv & S_AXIS_tvalid;
    assign w_end     = w_beat & (S_AXIS_tlast | (r_cnt == 12'd1023));
    assign w_apb_acc = S_APB_psel & S_APB_penable & ~r_pready;
    // r_ok requires a synchronized low after reset, so a level held across reset cannot arm
    assign w_cs_arm  = r_ok & (r_sync == 2'b01);
    assign w_reg_arm = w_apb_acc & S_APB_pwrite & (S_APB_paddr[31:12] == BASE_REG)
                     & (S_APB_paddr[11:0] == 12'h000) & S_APB_pwdata[0];
    assign w_arm     = (w_cs_arm | w_reg_arm) & ~w_recv;
    assign w_unused  = &{1'b0, S_APB_pwdata[31:1], S_APB_paddr[1:0]};

    always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
        if (!S_APB_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_recv ? (w_end ? S_DONE : S_RECV) : (w_arm ? S_RECV : r_state);
    end

    always_comb begin
        S_AXIS_tready = w_recv;
        Busy          = w_recv;
    end

    always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
        if (!S_APB_aresetn) begin
            r_sync <= 2'b00;
            r_live <= 1'b0;
            r_ok   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], Capture_start};
            r_live <= 1'b1;
            r_ok   <= r_ok | (r_live & ~r_sync[0]);
        end
    end

    always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
        if (!S_APB_aresetn) begin
            r_cnt  <= 12'd0;
            r_len  <= 12'd0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_arm) begin
            r_cnt  <= 12'd0;
            r_len  <= 12'd0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + 12'd1;
            if (w_end) begin
                r_len  <= r_cnt + 12'd1;
                r_done <= 1'b1;
                r_ovf  <= ~S_AXIS_tlast;
            end
        end
    end

    // capture buffer: stream write port, registered APB read port (read-before-write)
    always_ff @(posedge S_APB_aclk) begin
        if (w_beat) r_mem[r_cnt[9:0]] <= S_AXIS_tdata;
        r_mem_rd <= r_mem[S_APB_paddr[11:2]];
    end

    always_comb begin
        w_reg_val = (S_APB_paddr[31:12] != BASE_REG) ? 32'h0 :
                    (S_APB_paddr[11:0] == 12'h000) ? {28'h0, r_ovf, r_done, w_recv, 1'b0} :
                    (S_APB_paddr[11:0] == 12'h004) ? {20'h0, r_len} : 32'h0;
    end

    always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
        if (!S_APB_aresetn) begin
            r_pready  <= 1'b0;
            r_sel_mem <= 1'b0;
            r_reg_rd  <= 32'h0;
        end else begin
            r_pready  <= w_apb_acc;
            r_sel_mem <= ~S_APB_pwrite & (S_APB_paddr[31:12] == BASE_MEM);
            r_reg_rd  <= S_APB_pwrite ? 32'h0 : w_reg_val;
        end
    end

    assign S_APB_pready  = r_pready;
    assign S_APB_prdata  = r_pready ? (r_sel_mem ? r_mem_rd : r_reg_rd) : 32'h0;
    assign S_APB_pslverr = 1'b0;
    assign Done          = r_done;
    assign Overflow      = r_ovf;
    assign Rx_Length     = r_len;
endmodule

// File: tb/tb_output_mem.sv
// tb_output_mem: table vectors, directed corner sequences and random packets against a queue/array model.
module tb_output_mem;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        cs = 1'b0;
    logic [31:0] tdata = 32'h0;
    logic        tvalid = 1'b0, tlast = 1'b0;
    logic        tready, busy, done, ovf;
    logic [11:0] rx_len;

    always #5 clk = ~clk;

    output_mem dut (
        .S_APB_aclk(clk), .S_APB_aresetn(rstn),
        .S_APB_paddr(paddr), .S_APB_psel(psel), .S_APB_penable(penable),
        .S_APB_pwrite(pwrite), .S_APB_pwdata(pwdata),
        .S_APB_prdata(prdata), .S_APB_pready(pready), .S_APB_pslverr(pslverr),
        .Capture_start(cs),
        .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid), .S_AXIS_tlast(tlast), .S_AXIS_tready(tready),
        .Busy(busy), .Done(done), .Overflow(ovf), .Rx_Length(rx_len)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    int          n_chk = 0, n_err = 0;
    logic [31:0] m_mem [1024];
    bit          m_recv = 0, m_done = 0, m_ovf = 0;
    int          m_cnt = 0, m_len = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic m_arm();
        if (!m_recv) begin
            m_recv = 1; m_cnt = 0; m_len = 0; m_done = 0; m_ovf = 0;
        end
    endtask

    task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                            output logic [31:0] rd);
        int lat;
        lat = 0;
        rd = 32'h0;
        @(negedge clk);
        psel = 1; penable = 0; paddr = addr; pwrite = wr; pwdata = wd;
        @(negedge clk);
        penable = 1;
        for (int i = 0; i < 4 && lat == 0; i++) begin
            @(negedge clk);
            if (pready) begin
                lat = i + 1;
                rd = prdata;
            end
        end
        psel = 0; penable = 0; pwrite = 0;
        chk("apb_latency", lat, 1);
        if (wr && addr == 32'h43c02000 && wd[0]) m_arm();
        @(negedge clk);
        chk("apb_pready_pulse", {31'h0, pready}, 0);
        chk("apb_prdata_idle", prdata, 0);
    endtask

    task automatic arm_pin();
        @(negedge clk);
        cs = 1;
        @(negedge clk);
        chk("arm_sync_latency", {31'h0, tready}, {31'h0, m_recv});
        @(negedge clk);
        chk("arm_tready", {31'h0, tready}, 1);
        m_arm();
        cs = 0;
    endtask

    // gap_mode: 0 always valid, 1 valid every other cycle, 2 random gaps
    task automatic stream(input int n, input bit last_end, input int gap_mode,
                          input logic [31:0] base, input logic [31:0] step);
        int k, cyc, extra, bad;
        bit v;
        k = 0; cyc = 0; extra = 0; bad = 0;
        while (k < n && cyc < 4 * n + 40 && extra < 6) begin
            @(negedge clk);
            cyc++;
            if (tready !== m_recv) bad++;
            if (!m_recv) extra++;
            v = gap_mode == 0 ? 1'b1 : gap_mode == 1 ? cyc[0] : ($urandom_range(0, 2) != 0);
            tvalid = v;
            tdata  = base + k * step;
            tlast  = last_end && k == n - 1;
            if (v && m_recv) begin
                m_mem[m_cnt] = tdata;
                m_cnt++;
                k++;
                if (tlast || m_cnt == 1024) begin
                    m_recv = 0; m_done = 1; m_len = m_cnt; m_ovf = !tlast;
                end
            end
        end
        @(negedge clk);
        if (tready !== m_recv) bad++;
        tvalid = 0; tlast = 0;
        chk("tready_track", bad, 0);
    endtask

    task automatic chk_status();
        logic [31:0] rd;
        chk("busy", {31'h0, busy}, {31'h0, m_recv});
        chk("done", {31'h0, done}, {31'h0, m_done});
        chk("overflow", {31'h0, ovf}, {31'h0, m_ovf});
        chk("rx_length", {20'h0, rx_len}, m_len);
        apb_xfer(32'h43c02000, 0, 0, rd);
        chk("status_reg", rd, {28'h0, m_ovf, m_done, m_recv, 1'b0});
        apb_xfer(32'h43c02004, 0, 0, rd);
        chk("length_reg", rd, m_len);
    endtask

    task automatic chk_mem(input int a);
        logic [31:0] rd;
        apb_xfer(32'h43c01000 + a * 4, 0, 0, rd);
        chk($sformatf("mem[%0d]", a), rd, m_mem[a]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[9];
        logic [31:0] rd;
        int          n;
        vecs[0] = '{32'h43c01000, 32'h11};
        vecs[1] = '{32'h43c01004, 32'h22};
        vecs[2] = '{32'h43c01008, 32'h33};
        vecs[3] = '{32'h43c0100c, 32'h44};
        vecs[4] = '{32'h43c02000, 32'h4};
        vecs[5] = '{32'h43c02004, 32'h4};
        vecs[6] = '{32'h43c03000, 32'h0};
        vecs[7] = '{32'h43c02008, 32'h0};
        vecs[8] = '{32'h43c00ffc, 32'h0};

        repeat (3) @(negedge clk);
        chk("rst_tready", {31'h0, tready}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_overflow", {31'h0, ovf}, 0);
        chk("rst_rx_length", {20'h0, rx_len}, 0);
        chk("rst_pready", {31'h0, pready}, 0);
        chk("rst_prdata", prdata, 0);
        chk("pslverr", {31'h0, pslverr}, 0);
        rstn = 1;
        repeat (4) @(negedge clk);

        // basic 4-beat capture, then a BASE_MEM write that must not land, then table reads
        arm_pin();
        stream(4, 1, 0, 32'h11, 32'h11);
        chk_status();
        apb_xfer(32'h43c01000, 1, 32'hdeadbeef, rd);
        foreach (vecs[i]) begin
            apb_xfer(vecs[i].addr, 0, 0, rd);
            chk($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // tvalid toggling during an 8-beat packet
        arm_pin();
        stream(8, 1, 1, 32'h100, 32'h1);
        chk_status();
        for (int i = 0; i < 8; i++) chk_mem(i);

        // register arm ignored while receiving, honoured after Done
        arm_pin();
        stream(3, 0, 0, 32'h200, 32'h1);
        apb_xfer(32'h43c02000, 1, 32'h1, rd);
        chk_status();
        stream(2, 1, 0, 32'h203, 32'h1);
        chk_status();
        chk_mem(3);
        apb_xfer(32'h43c02000, 1, 32'h1, rd);
        chk_status();
        stream(1, 1, 0, 32'h300, 32'h1);
        chk_status();

        // random packets, armed by pin or register
        for (int p = 0; p < 6; p++) begin
            if ($urandom_range(0, 1) == 1) arm_pin();
            else apb_xfer(32'h43c02000, 1, 32'h1, rd);
            n = $urandom_range(1, 60);
            stream(n, 1, 2, $urandom, $urandom);
            chk_status();
            for (int j = 0; j < 4; j++) chk_mem($urandom_range(0, m_len - 1));
        end

        // overflow: 1030 beats without tlast
        arm_pin();
        stream(1030, 0, 0, 32'h1000, 32'h1);
        chk_status();
        chk_mem(0);
        chk_mem(1023);

        // reset in the middle of a capture
        arm_pin();
        stream(3, 0, 0, 32'h500, 32'h1);
        @(negedge clk);
        rstn = 0;
        #1;
        chk("midrst_tready", {31'h0, tready}, 0);
        chk("midrst_busy", {31'h0, busy}, 0);
        m_recv = 0; m_done = 0; m_ovf = 0; m_len = 0; m_cnt = 0;
        @(negedge clk);
        rstn = 1;
        repeat (3) @(negedge clk);
        chk_status();
        apb_xfer(32'h43c03000, 0, 0, rd);
        chk("unmapped_read", rd, 0);

        // Capture_start held high across reset release must not arm
        @(negedge clk);
        cs = 1;
        repeat (3) @(negedge clk);
        rstn = 0;
        repeat (2) @(negedge clk);
        rstn = 1;
        repeat (6) @(negedge clk);
        chk("held_no_arm_tready", {31'h0, tready}, 0);
        chk("held_no_arm_busy", {31'h0, busy}, 0);
        cs = 0;
        repeat (3) @(negedge clk);
        arm_pin();
        stream(2, 1, 0, 32'h600, 32'h1);
        chk_status();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
